// File: rtl/system_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// A write occurs when chipselect=1 and write_n=0; readdata is registered in the slave.
interface system_led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/system_led_pio.sv
// LED output PIO: data register with atomic set/clear, plus per-bit blink driven by a
// programmable half-period prescaler. Read data and LED drive are both registered.
module system_led_pio #(
  parameter int unsigned      WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [23:0]      DEFAULT_PERIOD = 24'd5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  system_led_pio_if.slave  bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] AddrData     = 3'd0;
  localparam logic [2:0] AddrBlinkEn  = 3'd1;
  localparam logic [2:0] AddrPeriod   = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrOutSet   = 3'd4;
  localparam logic [2:0] AddrOutClear = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [23:0]      period_q, period_d;
  logic [23:0]      cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rdata_d;

  logic             wr_en;
  logic             period_wr;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata_hi;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign period_wr = wr_en && (bus.address == AddrPeriod);
  assign wdata     = bus.writedata[WIDTH-1:0];
  // Bits 31:24 are never stored by any register.
  assign unused_wdata_hi = ^bus.writedata[31:24];

  // Register writes; addresses 3, 6 and 7 fall through and are ignored.
  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (bus.address)
        AddrData:     data_d   = wdata;
        AddrBlinkEn:  blink_d  = wdata;
        AddrPeriod:   period_d = bus.writedata[23:0];
        AddrOutSet:   data_d   = data_q | wdata;
        AddrOutClear: data_d   = data_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Prescaler; a PERIOD write restarts the half-period and wins over a coincident wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_wr || (period_q == 24'd0)) begin
      cnt_d   = 24'd0;
      phase_d = 1'b1;
    end else if (cnt_q == period_q - 24'd1) begin
      cnt_d   = 24'd0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  always_comb begin
    out_d = (data_q & ~blink_q) | (data_q & blink_q & {WIDTH{phase_q}});
  end

  // Readback is loaded every edge from the current address, independent of chipselect.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      AddrData:    rdata_d[WIDTH-1:0] = data_q;
      AddrBlinkEn: rdata_d[WIDTH-1:0] = blink_q;
      AddrPeriod:  rdata_d[23:0]      = period_q;
      AddrStatus:  rdata_d            = {cnt_q, 7'd0, phase_q};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= RESET_VALUE;
      blink_q      <= '0;
      period_q     <= DEFAULT_PERIOD;
      cnt_q        <= 24'd0;
      phase_q      <= 1'b1;
      out_q        <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      data_q       <= data_d;
      blink_q      <= blink_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      out_q        <= out_d;
      bus.readdata <= rdata_d;
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_system_led_pio.sv
// Self-checking bench for system_led_pio: directed vector table, hand-timed blink corner
// cases and random bus traffic against an elapsed-time reference model.
module tb_system_led_pio;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] out_port;

  system_led_pio_if bus ();

  system_led_pio #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: blink state derived from edges elapsed since the last period load.
  logic [W-1:0] m_data, m_blink;
  logic [23:0]  m_period;
  longint       m_ticks;
  logic [31:0]  m_exp_rd;
  logic [W-1:0] m_exp_out;

  task automatic model_reset();
    m_data    = '0;
    m_blink   = '0;
    m_period  = 24'd5000000;
    m_ticks   = 0;
    m_exp_rd  = '0;
    m_exp_out = '0;
  endtask

  task automatic model_edge(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd);
    longint p;
    longint cnt;
    logic   ph;
    p   = longint'(m_period);
    cnt = (p == 0) ? 0 : (m_ticks % p);
    ph  = (p == 0) ? 1'b1 : (((m_ticks / p) % 2) == 0);
    m_exp_out = m_data & (~m_blink | {W{ph}});
    case (a)
      3'd0:    m_exp_rd = {24'd0, m_data};
      3'd1:    m_exp_rd = {24'd0, m_blink};
      3'd2:    m_exp_rd = {8'd0, m_period};
      3'd3:    m_exp_rd = (32'(cnt) << 8) | {31'd0, ph};
      default: m_exp_rd = 32'd0;
    endcase
    m_ticks++;
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[W-1:0];
        3'd1: m_blink = wd[W-1:0];
        3'd2: begin
          m_period = wd[23:0];
          m_ticks  = 0;
        end
        3'd4: m_data = m_data | wd[W-1:0];
        3'd5: m_data = m_data & ~wd[W-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, clock, then compare DUT outputs to the model.
  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wd;
    @(posedge clk);
    model_edge(a, cs, wn, wd);
    #1;
    chk("model out_port", {24'd0, out_port}, {24'd0, m_exp_out});
    chk($sformatf("model readdata addr%0d", a), bus.readdata, m_exp_rd);
  endtask

  typedef struct {
    logic [2:0]   addr;
    logic         cs;
    logic         wn;
    logic [31:0]  wd;
    logic [31:0]  exp_rd;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[18];

  logic [2:0]  r_a;
  logic        r_cs;
  logic        r_wn;
  logic [31:0] r_wd;

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    reset_n        = 1'b0;
    model_reset();

    // Reset readback, then data write / set / clear, ignored writes and width masking.
    vecs[0]  = '{3'd3, 1'b1, 1'b1, 32'h0,        32'h0000_0001, 8'h00};
    vecs[1]  = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[2]  = '{3'd1, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[3]  = '{3'd2, 1'b1, 1'b1, 32'h0,        32'h004C_4B40, 8'h00};
    vecs[4]  = '{3'd4, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[5]  = '{3'd5, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[6]  = '{3'd6, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[7]  = '{3'd7, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h00};
    vecs[8]  = '{3'd0, 1'b1, 1'b0, 32'hA5,       32'h0000_0000, 8'h00};
    vecs[9]  = '{3'd4, 1'b1, 1'b0, 32'h0F,       32'h0000_0000, 8'hA5};
    vecs[10] = '{3'd5, 1'b1, 1'b0, 32'hA0,       32'h0000_0000, 8'hAF};
    vecs[11] = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h0000_000F, 8'h0F};
    vecs[12] = '{3'd0, 1'b0, 1'b0, 32'hFF,       32'h0000_000F, 8'h0F};
    vecs[13] = '{3'd6, 1'b1, 1'b0, 32'hFF,       32'h0000_0000, 8'h0F};
    vecs[14] = '{3'd1, 1'b1, 1'b0, 32'hFFFF_FF00, 32'h0000_0000, 8'h0F};
    vecs[15] = '{3'd1, 1'b1, 1'b1, 32'h0,        32'h0000_0000, 8'h0F};
    vecs[16] = '{3'd0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_000F, 8'h0F};
    vecs[17] = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h0000_0078, 8'h78};

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_port", {24'd0, out_port}, 32'd0);
    chk("reset readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
      chk($sformatf("vec%0d readdata", i), bus.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d out_port", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
    end

    // Blink with PERIOD=4, BLINK_EN=0x01, DATA=0x03; a deselected write changes nothing.
    cycle(3'd2, 1'b1, 1'b0, 32'd4);
    cycle(3'd1, 1'b1, 1'b0, 32'h01);
    cycle(3'd0, 1'b1, 1'b0, 32'h03);
    cycle(3'd0, 1'b0, 1'b0, 32'hFF);
    for (int i = 0; i < 16; i++) cycle(3'd3, 1'b1, 1'b1, 32'd0);

    // PERIOD=8 written on the wrap edge of a PERIOD=4 count.
    cycle(3'd2, 1'b1, 1'b0, 32'd4);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("wrap status c0", bus.readdata, 32'h0000_0001);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("wrap status c1", bus.readdata, 32'h0000_0101);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("wrap status c2", bus.readdata, 32'h0000_0201);
    cycle(3'd2, 1'b1, 1'b0, 32'd8);
    chk("wrap period read", bus.readdata, 32'h0000_0004);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("no toggle on reload", bus.readdata, 32'h0000_0001);
    for (int i = 0; i < 6; i++) cycle(3'd3, 1'b1, 1'b1, 32'd0);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("period8 last count", bus.readdata, 32'h0000_0701);
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("period8 toggle", bus.readdata, 32'h0000_0000);
    chk("period8 out_port", {24'd0, out_port}, 32'h0000_0002);

    // Asynchronous reset mid-blink, between clock edges.
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst out_port", {24'd0, out_port}, 32'd0);
    chk("async rst readdata", bus.readdata, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("post rst status", bus.readdata, 32'h0000_0001);
    cycle(3'd2, 1'b1, 1'b1, 32'd0);
    chk("post rst period", bus.readdata, 32'h004C_4B40);

    // PERIOD=0 freezes blink: blinking bits follow DATA.
    cycle(3'd2, 1'b1, 1'b0, 32'd0);
    cycle(3'd1, 1'b1, 1'b0, 32'hFF);
    cycle(3'd0, 1'b1, 1'b0, 32'h55);
    for (int i = 0; i < 6; i++) cycle(3'd3, 1'b1, 1'b1, 32'd0);
    chk("frozen status", bus.readdata, 32'h0000_0001);
    chk("frozen out_port", {24'd0, out_port}, 32'h0000_0055);

    // Random traffic with short periods so blinking is exercised.
    for (int i = 0; i < 600; i++) begin
      r_a  = 3'($urandom_range(0, 7));
      r_cs = ($urandom_range(0, 3) != 0);
      r_wn = ($urandom_range(0, 2) != 0);
      r_wd = $urandom();
      if (r_a == 3'd2) r_wd = (r_wd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
      cycle(r_a, r_cs, r_wn, r_wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
